ble_cfg_loader: RTL



---
 rtl/ble_cfg_loader_pkg.sv | 28 ++
 rtl/ble_cfg_loader_if.sv | 24 ++
 rtl/ble_cfg_loader_crc8.sv | 24 ++
 rtl/ble_cfg_loader.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ble_cfg_loader_pkg.sv
// Shared types and constants for the cluster config loader: state codes, per-BLE field offsets, CRC-8 setup.
// Field offsets for the control bits are relative to the top of the LUT mask (bit 2**K).
package ble_cfg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_CHECK = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  localparam int MASK_LSB     = 0;
  localparam int FF_USED_OFS  = 0;
  localparam int EN_USED_OFS  = 1;
  localparam int RST_USED_OFS = 2;
  localparam int SET_USED_OFS = 3;
  localparam int CTRL_BITS    = 4;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int         CRC_BITS  = 8;

  function automatic int cfg_w(input int k);
    return (1 << k) + CTRL_BITS;
  endfunction

endpackage

// File: rtl/ble_cfg_loader_if.sv
// Serial config stream plus committed-image bus; master drives the stream, slave is the loader.
interface ble_cfg_loader_if #(parameter int TOTAL_BITS = 160);

  logic                  start;
  logic                  abort;
  logic                  in_valid;
  logic                  in_bit;
  logic                  in_ready;
  logic [TOTAL_BITS-1:0] cfg_out;
  logic                  cfg_done;
  logic                  cfg_err;
  logic                  busy;

  modport master (
    output start, abort, in_valid, in_bit,
    input  in_ready, cfg_out, cfg_done, cfg_err, busy
  );

  modport slave (
    input  start, abort, in_valid, in_bit,
    output in_ready, cfg_out, cfg_done, cfg_err, busy
  );

endinterface

// File: rtl/ble_cfg_loader_crc8.sv
// Bit-serial CRC-8 (MSB first), one bit per enabled cycle; clr reloads the init value.
module crc8_serial
  import ble_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic fb;
  assign fb = crc[7] ^ din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ ({8{fb}} & CRC8_POLY);
    end
  end

endmodule

// File: rtl/ble_cfg_loader.sv
// Serial-to-parallel BLE cluster config loader; commits 1 cycle after the last bit (2 with BLE_CFG_CRC_EN).
// in_ready is high only while loading; the shadow image is committed atomically to cfg_out.
module ble_cfg_loader
  import ble_cfg_pkg::*;
#(
  parameter int NUM_BLE = 8,
  parameter int LUT_K   = 4
)
(
  input  logic            clk,
  input  logic            rst,
  ble_cfg_loader_if.slave bus
);

  localparam int CFG_W      = cfg_w(LUT_K);
  localparam int TOTAL_BITS = NUM_BLE * CFG_W;
`ifdef BLE_CFG_CRC_EN
  localparam int LOAD_BITS  = TOTAL_BITS + CRC_BITS;
`else
  localparam int LOAD_BITS  = TOTAL_BITS;
`endif
  localparam int CNT_W      = $clog2(TOTAL_BITS + 8);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LOAD_BITS - 1);

  state_t                  state;
  logic [TOTAL_BITS-1:0]   shadow;
  logic [TOTAL_BITS-1:0]   cfg_q;
  logic [TOTAL_BITS-1:0]   shadow_next;
  logic [CNT_W-1:0]        cnt;
  logic                    done_q;
  logic                    accept;
  logic                    last;
  logic                    kickoff;

  assign accept      = (state == ST_LOAD) && bus.in_valid;
  assign last        = accept && (cnt == LAST_IDX);
  assign kickoff     = bus.start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  assign shadow_next = {shadow[TOTAL_BITS-2:0], bus.in_bit};

`ifdef BLE_CFG_CRC_EN
  logic       err_q;
  logic [7:0] crc_q;
  logic       crc_ok;
  logic       payload_bit;

  // Trailing CRC bits are fed through the same register, so a good stream leaves a zero residue.
  crc8_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (kickoff),
    .en  (accept),
    .din (bus.in_bit),
    .crc (crc_q)
  );

  assign crc_ok      = (crc_q == 8'h00);
  assign payload_bit = (cnt < CNT_W'(TOTAL_BITS));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      shadow <= '0;
      cfg_q  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
`ifdef BLE_CFG_CRC_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            state  <= ST_LOAD;
            cnt    <= '0;
            shadow <= '0;
            done_q <= 1'b0;
`ifdef BLE_CFG_CRC_EN
            err_q  <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            shadow <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
          end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
`ifdef BLE_CFG_CRC_EN
            if (payload_bit) begin
              shadow <= shadow_next;
            end
            if (last) begin
              state <= ST_CHECK;
            end
`else
            shadow <= shadow_next;
            if (last) begin
              state  <= ST_DONE;
              cfg_q  <= shadow_next;
              done_q <= 1'b1;
            end
`endif
          end
        end
`ifdef BLE_CFG_CRC_EN
        ST_CHECK: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            shadow <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
          end else if (crc_ok) begin
            state  <= ST_DONE;
            cfg_q  <= shadow;
            done_q <= 1'b1;
          end else begin
            state <= ST_ERR;
            err_q <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == ST_LOAD);
  assign bus.busy     = (state == ST_LOAD) || (state == ST_CHECK);
  assign bus.cfg_out  = cfg_q;
  assign bus.cfg_done = done_q;
`ifdef BLE_CFG_CRC_EN
  assign bus.cfg_err  = err_q;
`else
  assign bus.cfg_err  = 1'b0;
`endif

endmodule
